// File: rtl/dp_mem_stream_reader.sv
// Read-side DMA stage for port b of the dual-port buffer memory: walks an address
// range one read per cycle and streams the words out through a 2-entry skid buffer.
module dp_mem_stream_reader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   length,
    input  logic              abort,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_dat_in,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    localparam logic [ADDR_W:0]   MAX_LEN  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_last_addr;
    logic [ADDR_W:0]     r_remaining;
    logic                r_inflight;
    logic                r_inflight_last;
    logic                r_zero_done;
    logic [1:0]          r_cnt;
    logic [DATA_W-1:0]   r_data0;
    logic [DATA_W-1:0]   r_data1;
    logic                r_last0;
    logic                r_last1;

    logic [ADDR_W:0]     w_len_clamped;
    logic                w_pop;
    logic                w_push;
    logic [1:0]          w_occ;
    logic                w_issue;
    logic                w_accept;
    logic                w_drain_done;

    assign w_len_clamped = (length > MAX_LEN) ? MAX_LEN : length;
    assign w_pop         = (r_cnt != 2'd0) && out_ready;
    assign w_push        = r_inflight;
    // Occupancy the buffer would reach if nothing new were issued this cycle.
    assign w_occ         = r_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
    assign w_issue       = (r_state == S_RUN) && (r_remaining != '0) && (w_occ < 2'd2) && !abort;
    assign w_accept      = (r_state == S_IDLE) && start && !abort;

    assign mem_address = w_issue ? r_addr : r_last_addr;
    assign mem_wr      = 1'b0;
    assign out_data    = r_data0;
    assign out_valid   = (r_cnt != 2'd0);
    assign out_last    = r_last0 && out_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_drain_done = 1'b0;
        if (abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && (length != '0)) w_next = S_RUN;
                end
                S_RUN: begin
                    if (w_issue && (r_remaining == LEN_ONE)) w_next = S_DRAIN;
                end
                S_DRAIN: begin
                    if (!r_inflight && (r_cnt == 2'd0)) begin
                        w_next       = S_IDLE;
                        w_drain_done = 1'b1;
                    end
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE) && !w_drain_done;
    assign done = w_drain_done || r_zero_done;

    // Address generation and read issue.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr          <= '0;
            r_last_addr     <= '0;
            r_remaining     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_zero_done     <= 1'b0;
        end else begin
            r_zero_done     <= w_accept && (length == '0);
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (r_remaining == LEN_ONE);
            if (w_accept) begin
                r_addr      <= start_addr;
                r_remaining <= w_len_clamped;
            end else if (w_issue) begin
                r_addr      <= r_addr + ADDR_ONE;
                r_remaining <= r_remaining - LEN_ONE;
                r_last_addr <= r_addr;
            end
        end
    end

    // Capture stage: two-entry FIFO, entry 0 is the registered stream head.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= 2'd0;
            r_data0 <= '0;
            r_last0 <= 1'b0;
        end else if (abort) begin
            r_cnt <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) begin
                        r_data0 <= mem_dat_in;
                        r_last0 <= r_inflight_last;
                    end else begin
                        r_data1 <= mem_dat_in;
                        r_last1 <= r_inflight_last;
                    end
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_data0 <= r_data1;
                    r_last0 <= r_last1;
                    r_cnt   <= r_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_cnt == 2'd1) begin
                        r_data0 <= mem_dat_in;
                        r_last0 <= r_inflight_last;
                    end else begin
                        r_data0 <= r_data1;
                        r_last0 <= r_last1;
                        r_data1 <= mem_dat_in;
                        r_last1 <= r_inflight_last;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dp_mem_stream_reader.sv
// Bench for dp_mem_stream_reader: a registered-read memory model, a table of
// transfers with hand-computed results, corner sequences and randomized transfers.
module tb_dp_mem_stream_reader;

    logic        clk = 1'b0;
    logic        reset, start, abort, out_ready;
    logic [9:0]  start_addr, mem_address;
    logic [10:0] length;
    logic        mem_wr, out_valid, out_last, busy, done;
    logic [15:0] mem_dat_in = 16'h0;
    logic [15:0] out_data;
    logic [15:0] mem [1024];

    int checks = 0;
    int errors = 0;

    dp_mem_stream_reader #(.ADDR_W(10), .DATA_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
        .length(length), .abort(abort), .mem_address(mem_address), .mem_wr(mem_wr),
        .mem_dat_in(mem_dat_in), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Memory port b: registered read, output refreshed every clock.
    always @(posedge clk) mem_dat_in <= mem[mem_address];

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One transfer. Starts one cycle after the call (post-edge), returns at a negedge.
    task automatic xfer(input logic [9:0] a, input logic [10:0] l, input int pct,
                        input int abort_after, input bit second,
                        output int n_rx, output int first_w, output int last_w,
                        output int first_vld_cyc, output int done_cyc);
        int nn, hs, bad_last, bad_busy, bad_wr, mism, abort_ph;
        bit stall;
        logic [15:0] pd;
        logic pl;
        int exp_q[$];
        int rx[$];
        nn = (int'(l) > 1024) ? 1024 : int'(l);
        for (int k = 0; k < nn; k++) exp_q.push_back(int'(mem[(int'(a) + k) % 1024]));
        hs = 0; bad_last = 0; bad_busy = 0; bad_wr = 0; mism = 0; abort_ph = 0;
        stall = 1'b0; pd = '0; pl = 1'b0;
        first_vld_cyc = -1; done_cyc = -1;
        @(posedge clk); #1;
        start_addr = a; length = l; start = 1'b1; abort = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("idle_no_valid", {31'd0, out_valid}, 32'd0);
        for (int cyc = 1; cyc < 4000; cyc++) begin
            @(posedge clk); #1;
            start = 1'b0; abort = 1'b0;
            out_ready = ($urandom_range(0, 99) < pct);
            if (second && cyc == 2) begin
                start = 1'b1; start_addr = 10'h300; length = 11'd5;
            end
            if (abort_ph == 1) abort = 1'b1;
            @(negedge clk);
            if (mem_wr !== 1'b0) bad_wr++;
            if (stall) check("stall_hold", {14'd0, out_valid, out_last, out_data}, {14'd0, 1'b1, pl, pd});
            if (abort_ph == 2) begin
                check("abort_valid", {31'd0, out_valid}, 32'd0);
                check("abort_busy", {31'd0, busy}, 32'd0);
                check("abort_done", {31'd0, done}, 32'd0);
                break;
            end
            if (abort_ph == 1) begin
                check("abort_cycle_done", {31'd0, done}, 32'd0);
                abort_ph = 2;
                stall = 1'b0;
                continue;
            end
            if (out_valid === 1'b1 && first_vld_cyc < 0) first_vld_cyc = cyc;
            if (done === 1'b1) begin
                done_cyc = cyc;
                check("busy_at_done", {31'd0, busy}, 32'd0);
                break;
            end
            if (busy !== 1'b1 && nn > 0) bad_busy++;
            stall = out_valid && !out_ready;
            pd = out_data; pl = out_last;
            if (out_valid && out_ready) begin
                rx.push_back(int'(out_data));
                if (out_last !== (hs == nn - 1)) bad_last++;
                hs++;
                if (hs == abort_after) abort_ph = 1;
            end
        end
        for (int k = 0; k < rx.size() && k < nn; k++) if (rx[k] != exp_q[k]) mism++;
        check("stream_mismatches", mism, 0);
        check("mem_wr_seen", bad_wr, 0);
        if (abort_after < 0) begin
            check("word_count", rx.size(), nn);
            check("last_flag_errors", bad_last, 0);
            check("done_seen", {31'd0, done_cyc >= 0}, 32'd1);
            if (nn > 0) check("busy_gaps", bad_busy, 0);
        end
        n_rx = rx.size();
        first_w = (rx.size() > 0) ? rx[0] : -1;
        last_w  = (rx.size() > 0) ? rx[rx.size() - 1] : -1;
    endtask

    typedef struct {
        logic [9:0]  a;
        logic [10:0] l;
        int          pct;
        int          exp_n;
        int          exp_first;
        int          exp_last;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int n, fw, lw, fv, dc;
        tbl[0] = '{10'h010, 11'd4,    100, 4,    'h110, 'h113};
        tbl[1] = '{10'd1022, 11'd4,   100, 4,    'h4FE, 'h101};
        tbl[2] = '{10'h030, 11'd8,    50,  8,    'h130, 'h137};
        tbl[3] = '{10'h000, 11'd0,    100, 0,    0,     0};
        tbl[4] = '{10'd5,   11'd1024, 100, 1024, 'h105, 'h104};
        tbl[5] = '{10'h000, 11'd1500, 70,  1024, 'h100, 'h4FF};
        for (int i = 0; i < 1024; i++) mem[i] = 16'(i + 'h100);

        reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        start_addr = '0; length = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_address", {22'd0, mem_address}, 32'd0);
        check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        check("rst_out_data", {16'd0, out_data}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_last", {31'd0, out_last}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            xfer(tbl[i].a, tbl[i].l, tbl[i].pct, -1, 1'b0, n, fw, lw, fv, dc);
            check("tbl_count", n, tbl[i].exp_n);
            if (tbl[i].exp_n > 0) begin
                check("tbl_first", fw, tbl[i].exp_first);
                check("tbl_last", lw, tbl[i].exp_last);
            end else begin
                check("zero_len_no_valid", fv, -1);
            end
            if (tbl[i].pct == 100) begin
                if (tbl[i].exp_n > 0) check("first_valid_cycle", fv, 3);
                check("done_cycle", dc, (tbl[i].exp_n == 0) ? 1 : tbl[i].exp_n + 3);
            end
        end

        // Abort after the 6th handshake, then a fresh short transfer.
        xfer(10'h040, 11'd16, 100, 6, 1'b0, n, fw, lw, fv, dc);
        check("abort_no_done_pulse", dc, -1);
        xfer(10'h200, 11'd2, 100, -1, 1'b0, n, fw, lw, fv, dc);
        check("post_abort_count", n, 2);
        check("post_abort_first", fw, 'h300);
        check("post_abort_last", lw, 'h301);

        // A second start during RUN must not change the transfer.
        xfer(10'h050, 11'd6, 100, -1, 1'b1, n, fw, lw, fv, dc);
        check("busy_start_count", n, 6);
        check("busy_start_last", lw, 'h155);

        // Reset while in DRAIN.
        @(posedge clk); #1;
        start_addr = 10'h060; length = 11'd3; start = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("drain_busy", {31'd0, busy}, 32'd1);
        check("drain_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("drst_mem_address", {22'd0, mem_address}, 32'd0);
        check("drst_out_data", {16'd0, out_data}, 32'd0);
        check("drst_out_valid", {31'd0, out_valid}, 32'd0);
        check("drst_out_last", {31'd0, out_last}, 32'd0);
        check("drst_busy", {31'd0, busy}, 32'd0);
        check("drst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        check("drst_done_later", {31'd0, done}, 32'd0);

        // Randomized transfers over random memory contents.
        for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
        for (int t = 0; t < 10; t++) begin
            xfer(10'($urandom_range(0, 1023)), 11'($urandom_range(1, 40)),
                 $urandom_range(25, 100), -1, 1'b0, n, fw, lw, fv, dc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dp_mem_stream_reader.md
# dp_mem_stream_reader

Read-side DMA stage that sits on port b of the 1024×16 true dual-port buffer memory. On a start command it walks a programmed address range, issuing one read per cycle. It absorbs the memory's one-cycle registered read latency in a 2-entry skid buffer and presents the words downstream as a valid/ready stream with a last marker. The block never writes the memory.

## Interface
- ADDR_W, 10, memory address width (1024 words)
- DATA_W, 16, word width
- clk  in  1  single clock; memory port b runs on this clock
- reset  in  1  synchronous, active-high
- start  in  1  command strobe; sampled only in IDLE
- start_addr  in  ADDR_W  first word address
- length  in  ADDR_W+1  word count, 0..1024; values above 1024 clamp to 1024
- abort  in  1  synchronous cancel of the current transfer
- mem_address  out  ADDR_W  to memory address_b
- mem_wr  out  1  to memory wr_b; constant 0
- mem_dat_in  in  DATA_W  from memory dat_out_b; valid one cycle after address is sampled
- out_data  out  DATA_W  stream data
- out_valid  out  1  stream valid
- out_ready  in  1  downstream ready
- out_last  out  1  high with the final word of a transfer
- busy  out  1  high from the cycle after start acceptance until done
- done  out  1  one-cycle pulse on normal completion

## Operation
- **States:** IDLE, RUN, DRAIN.
- **IDLE**
  - start=1 and length≠0: latch start_addr into the address counter and min(length,1024) into the remaining counter, then go to RUN.
  - start=1 and length=0: no reads; done pulses the next cycle; busy stays 0.
- **RUN, read issue**
  - A read is issued when remaining>0 and (buffer entries + in-flight − pop this cycle) < 2, where pop = out_valid & out_ready.
  - An issue presents the counter on mem_address and sets the in-flight flag for the next cycle.
  - It then increments the address modulo 1024 (1023 wraps to 0) and decrements remaining.
  - When remaining reaches 0, go to DRAIN.
- **Capture**
  - When the in-flight flag is set, mem_dat_in is written into the buffer.
  - mem_dat_in in cycles without the in-flight flag is ignored. The memory updates dat_out every clock.
- **Buffer**
  - 2-entry FIFO with registered outputs. out_data and out_valid come from the head entry.
  - Push and pop in the same cycle are legal at any occupancy.
- **out_last**
  - Each entry carries a last bit, set on the word from the final issue.
- **DRAIN**
  - Waits until in-flight=0 and the buffer is empty, i.e. the last word has handshaken.
  - Then: done=1 and busy=0 in the same cycle, go to IDLE.
- start while busy is ignored. There is no queuing.
- **abort (any state)**
  - Next cycle: state IDLE, buffer flushed, in-flight cleared, out_valid=0, busy=0.
  - No done pulse.
  - abort has priority over start in the same cycle.
- While out_valid=1 and out_ready=0, out_data and out_last hold stable.
- mem_address when nothing is issued: holds its last value. Downstream must not rely on it.

## Timing
- **Reset values:**
  - state IDLE
  - mem_address 0, mem_wr 0
  - out_data 0, out_valid 0, out_last 0
  - busy 0, done 0
  - buffer and in-flight cleared
- reset in mid-transfer behaves like abort.
- **Start accepted at cycle N:**
  - busy=1 and first mem_address valid at N+1.
  - Memory samples at the end of N+1; mem_dat_in is valid at N+2 and captured at the end of N+2.
  - out_valid=1 at N+3.
- **Throughput:** with out_ready held 1, one word per cycle after the first word. A transfer of L words has its last beat at N+2+L, and done at N+3+L.
- Back-pressure loses and duplicates no words. At most 2 words are buffered plus 1 in flight, and that never overflows.

## Test plan
- **Basic read:** memory[i]=i+0x100; start_addr=0x010, length=4, out_ready=1.
  - Stream 0x110, 0x111, 0x112, 0x113 at N+3..N+6.
  - out_last only on 0x113; done at N+7.
- **Wrap-around:** start_addr=1022, length=4.
  - Addresses 1022, 1023, 0, 1 in order; data matches.
- **Back-pressure:** length=8, out_ready toggled 1,0,0,1,0,1… randomly.
  - All 8 words in order, no drops or duplicates; out_data stable while stalled.
  - Issue stalls at most 3 words ahead of the handshake point.
- **Length boundaries:**
  - length=0: done pulse at N+1, no out_valid.
  - length=1024 from addr 5: 1024 words, last word from address 4.
  - length=1500: clamps to 1024.
- **Abort mid-transfer:** length=16, abort asserted after the 6th handshake.
  - Next cycle: out_valid=0, busy=0, no done.
  - A new start (addr 0x200, length 2) then yields exactly 2 correct words.
- **Start while busy and reset mid-transfer:**
  - A second start during RUN is ignored (word count unchanged).
  - reset asserted in DRAIN drives all outputs to reset values on the next cycle.
